gc_refresh_scheduler: RTL and testbench

//  Rotating-spare refresh sequencer for the gain-cell DRAM wrapper array.
//  N_BANKS physical wrappers hold N_BANKS-1 logical banks plus one spare. On each retention

---
 rtl/gc_refresh_scheduler.sv | 174 +++++++++++++++++
 tb/tb_gc_refresh_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/gc_refresh_scheduler.sv
// gc_refresh_scheduler: rotating-spare refresh sequencer for the gain-cell
// DRAM wrapper array. Each retention interval one logical bank is copied into
// the spare wrapper; then the logical bank is remapped onto the copy and the
// old wrapper becomes the new spare.
module gc_refresh_scheduler #(
  parameter int N_BANKS    = 4,
  parameter int RET_CYCLES = 1024,
  parameter int TIMEOUT    = 512,
  localparam int N_LOG     = N_BANKS - 1,
  localparam int IDX_W     = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [N_BANKS-1:0]     ref_done,
  output logic [N_BANKS-1:0]     start_sr,
  output logic [N_BANKS-1:0]     ref_en_current,
  output logic [N_BANKS-1:0]     ref_en_old,
  output logic                   busy,
  output logic [N_LOG*IDX_W-1:0] bank_map,
  output logic [IDX_W-1:0]       spare_idx,
  output logic [15:0]            refresh_cnt,
  output logic                   ref_err,
  output logic                   ref_overrun
);

  localparam int TMR_W = $clog2(RET_CYCLES);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(RET_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LOG_LAST   = IDX_W'(N_LOG - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_REFRESH,
    ST_SWAP,
    ST_ABORT
  } state_t;

  state_t state_q, state_d;

  logic [TMR_W-1:0] timer_q;
  logic             pending_q;
  logic [WD_W-1:0]  wdog_q;
  logic [IDX_W-1:0] src_q, dst_q;
  logic [IDX_W-1:0] map_q [N_LOG];
  logic [IDX_W-1:0] spare_q;
  logic [IDX_W-1:0] log_ptr_q;
  logic [15:0]      cnt_q;
  logic             err_q;
  logic             ovr_q;

  logic             expire;
  logic             start_req;
  logic             done_hit;
  logic             in_idle;
  logic [N_BANKS-1:0] src_oh, dst_oh;

  assign in_idle   = (state_q == ST_IDLE);
  assign expire    = enable && (timer_q == '0);
  assign start_req = enable && (pending_q || expire);
  assign done_hit  = ref_done[dst_q];
  assign src_oh    = N_BANKS'(1) << src_q;
  assign dst_oh    = N_BANKS'(1) << dst_q;

  // State register; reset returns straight to IDLE even mid-refresh.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; a done on the dest wrapper beats a same-cycle watchdog timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_req) state_d = ST_START;
      ST_START:   state_d = ST_REFRESH;
      ST_REFRESH: begin
        if (done_hit)              state_d = ST_SWAP;
        else if (wdog_q == WD_LAST) state_d = ST_ABORT;
      end
      ST_SWAP:    state_d = ST_IDLE;
      ST_ABORT:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Retention timer with a one-deep pending request; an expiry while busy is flagged as overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= TMR_RELOAD;
      pending_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      if (enable) begin
        if (timer_q == '0) timer_q <= TMR_RELOAD;
        else               timer_q <= timer_q - 1'b1;
      end
      if (in_idle && start_req) begin
        pending_q <= 1'b0;
      end else if (expire) begin
        pending_q <= 1'b1;
        if (!in_idle) ovr_q <= 1'b1;
      end
    end
  end

  // Operation datapath: latch src/dst at launch, run the watchdog, commit the remap on SWAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q     <= '0;
      dst_q     <= '0;
      wdog_q    <= '0;
      spare_q   <= IDX_W'(N_BANKS - 1);
      log_ptr_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      for (int l = 0; l < N_LOG; l++) map_q[l] <= IDX_W'(l);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            src_q <= map_q[log_ptr_q];
            dst_q <= spare_q;
          end
        end
        ST_START:   wdog_q <= '0;
        ST_REFRESH: wdog_q <= wdog_q + 1'b1;
        ST_SWAP: begin
          map_q[log_ptr_q] <= dst_q;
          spare_q          <= src_q;
          log_ptr_q        <= (log_ptr_q == LOG_LAST) ? '0 : log_ptr_q + 1'b1;
          cnt_q            <= cnt_q + 16'd1;
        end
        ST_ABORT:   err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // Moore decode of wrapper controls from the registered state and latched src/dst.
  always_comb begin
    start_sr       = '0;
    ref_en_current = '0;
    ref_en_old     = '0;
    case (state_q)
      ST_START: begin
        start_sr       = dst_oh;
        ref_en_current = dst_oh;
        ref_en_old     = src_oh;
      end
      ST_REFRESH: begin
        ref_en_current = dst_oh;
        ref_en_old     = src_oh;
      end
      default: ;
    endcase
  end

  // Flatten the logical->physical map for the user path.
  always_comb begin
    bank_map = '0;
    for (int l = 0; l < N_LOG; l++) bank_map[l*IDX_W +: IDX_W] = map_q[l];
  end

  assign busy        = !in_idle;
  assign spare_idx   = spare_q;
  assign refresh_cnt = cnt_q;
  assign ref_err     = err_q;
  assign ref_overrun = ovr_q;

endmodule

// File: tb/tb_gc_refresh_scheduler.sv
// tb_gc_refresh_scheduler: directed bench for the rotating-spare refresh
// sequencer. dut_a (RET_CYCLES=8, TIMEOUT=16) covers reset, rotation, overrun,
// done-vs-timeout and mid-refresh reset; dut_b (RET_CYCLES=4, TIMEOUT=4) covers abort/retry.
module tb_gc_refresh_scheduler;

  logic clk;

  logic       rst_a, enable_a;
  logic [3:0] ref_done_a, start_sr_a, cur_a, old_a;
  logic       busy_a, err_a, ovr_a;
  logic [5:0] map_a;
  logic [1:0] spare_a;
  logic [15:0] cnt_a;

  logic       rst_b, enable_b;
  logic [3:0] ref_done_b, start_sr_b, cur_b, old_b;
  logic       busy_b, err_b, ovr_b;
  logic [5:0] map_b;
  logic [1:0] spare_b;
  logic [15:0] cnt_b;

  int total = 0;
  int bad   = 0;

  gc_refresh_scheduler #(.N_BANKS(4), .RET_CYCLES(8), .TIMEOUT(16)) dut_a (
    .clk(clk), .rst(rst_a), .enable(enable_a), .ref_done(ref_done_a),
    .start_sr(start_sr_a), .ref_en_current(cur_a), .ref_en_old(old_a),
    .busy(busy_a), .bank_map(map_a), .spare_idx(spare_a),
    .refresh_cnt(cnt_a), .ref_err(err_a), .ref_overrun(ovr_a)
  );

  gc_refresh_scheduler #(.N_BANKS(4), .RET_CYCLES(4), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst(rst_b), .enable(enable_b), .ref_done(ref_done_b),
    .start_sr(start_sr_b), .ref_en_current(cur_b), .ref_en_old(old_b),
    .busy(busy_b), .bank_map(map_b), .spare_idx(spare_b),
    .refresh_cnt(cnt_b), .ref_err(err_b), .ref_overrun(ovr_b)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something upstream never returns.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are stable 1 unit after the edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a start pulse on dut_a, then run one copy with done after 'delay' cycles.
  task automatic applyStimulus(input string tag, input int exp_wait,
                               input logic [3:0] src_oh, input logic [3:0] dst_oh,
                               input int delay, input logic [5:0] exp_map,
                               input logic [1:0] exp_spare, input logic [15:0] exp_cnt);
    int  waited;
    bit  seen;
    waited = 0;
    seen   = 0;
    while (!seen && waited < 40) begin
      tick();
      waited++;
      if (start_sr_a != 4'b0) seen = 1;
    end
    checkOutput({tag, "_wait"},  waited,     exp_wait);
    checkOutput({tag, "_start"}, start_sr_a, dst_oh);
    checkOutput({tag, "_cur"},   cur_a,      dst_oh);
    checkOutput({tag, "_old"},   old_a,      src_oh);
    tick();
    checkOutput({tag, "_pulse_off"}, start_sr_a, 4'b0);
    checkOutput({tag, "_cur_held"},  cur_a,      dst_oh);
    for (int i = 1; i < delay; i++) tick();
    ref_done_a = dst_oh;
    tick();
    ref_done_a = 4'b0;
    checkOutput({tag, "_swap_busy"}, busy_a, 1'b1);
    checkOutput({tag, "_swap_cur"},  cur_a,  4'b0);
    tick();
    checkOutput({tag, "_map"},   map_a,   exp_map);
    checkOutput({tag, "_spare"}, spare_a, exp_spare);
    checkOutput({tag, "_cnt"},   cnt_a,   exp_cnt);
    checkOutput({tag, "_idle"},  busy_a,  1'b0);
  endtask

  // Main directed sequence.
  initial begin
    int  waited;
    bit  seen;

    rst_a = 1'b1; enable_a = 1'b0; ref_done_a = 4'b0;
    rst_b = 1'b1; enable_b = 1'b0; ref_done_b = 4'b0;
    repeat (3) tick();

    checkOutput("rst_map",   map_a,      6'b10_01_00);
    checkOutput("rst_spare", spare_a,    2'd3);
    checkOutput("rst_busy",  busy_a,     1'b0);
    checkOutput("rst_start", start_sr_a, 4'b0);
    checkOutput("rst_cur",   cur_a,      4'b0);
    checkOutput("rst_old",   old_a,      4'b0);
    checkOutput("rst_cnt",   cnt_a,      16'd0);
    checkOutput("rst_flags", {err_a, ovr_a}, 2'b00);

    rst_a = 1'b0; enable_a = 1'b1;
    rst_b = 1'b0;

    applyStimulus("r1", 8, 4'b0001, 4'b1000, 5, 6'b10_01_11, 2'd0, 16'd1);
    applyStimulus("r2", 1, 4'b0010, 4'b0001, 5, 6'b10_00_11, 2'd1, 16'd2);
    applyStimulus("r3", 1, 4'b0100, 4'b0010, 5, 6'b01_00_11, 2'd2, 16'd3);
    applyStimulus("r4", 1, 4'b1000, 4'b0100, 5, 6'b01_00_10, 2'd3, 16'd4);
    checkOutput("no_overrun", ovr_a, 1'b0);

    // Long copy: the timer expires mid-refresh, so the next one follows immediately.
    applyStimulus("r5", 1, 4'b0001, 4'b1000, 10, 6'b01_11_10, 2'd0, 16'd5);
    checkOutput("overrun", ovr_a, 1'b1);

    // A done on a non-destination wrapper must be ignored.
    waited = 0;
    seen   = 0;
    while (!seen && waited < 40) begin
      tick();
      waited++;
      if (start_sr_a != 4'b0) seen = 1;
    end
    checkOutput("r6_wait",  waited,     1);
    checkOutput("r6_start", start_sr_a, 4'b0001);
    checkOutput("r6_old",   old_a,      4'b0010);
    tick();
    ref_done_a = 4'b1110;
    tick();
    ref_done_a = 4'b0;
    checkOutput("wrong_done_busy", busy_a, 1'b1);
    checkOutput("wrong_done_cur",  cur_a,  4'b0001);
    repeat (2) tick();
    ref_done_a = 4'b0001;
    tick();
    ref_done_a = 4'b0;
    tick();
    checkOutput("r6_map",   map_a,   6'b00_11_10);
    checkOutput("r6_spare", spare_a, 2'd1);
    checkOutput("r6_cnt",   cnt_a,   16'd6);

    // Done lands in the same cycle as the last watchdog count: SWAP wins.
    applyStimulus("r7", 1, 4'b0100, 4'b0010, 16, 6'b00_11_01, 2'd2, 16'd7);
    checkOutput("r7_no_err", err_a, 1'b0);

    // Drop enable mid-operation (no abort), then reset in REFRESH.
    waited = 0;
    seen   = 0;
    while (!seen && waited < 40) begin
      tick();
      waited++;
      if (start_sr_a != 4'b0) seen = 1;
    end
    checkOutput("r8_start", start_sr_a, 4'b0100);
    checkOutput("r8_old",   old_a,      4'b1000);
    enable_a = 1'b0;
    repeat (2) tick();
    checkOutput("en_off_busy", busy_a, 1'b1);
    checkOutput("en_off_cur",  cur_a,  4'b0100);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    checkOutput("mid_rst_map",   map_a,   6'b10_01_00);
    checkOutput("mid_rst_spare", spare_a, 2'd3);
    checkOutput("mid_rst_busy",  busy_a,  1'b0);
    checkOutput("mid_rst_en",    {cur_a, old_a}, 8'h00);
    checkOutput("mid_rst_cnt",   cnt_a,   16'd0);
    checkOutput("mid_rst_flags", {err_a, ovr_a}, 2'b00);
    repeat (3) tick();
    checkOutput("frozen_idle", busy_a, 1'b0);

    // Abort path on dut_b: no done ever arrives.
    enable_b = 1'b1;
    waited = 0;
    seen   = 0;
    while (!seen && waited < 40) begin
      tick();
      waited++;
      if (start_sr_b != 4'b0) seen = 1;
    end
    checkOutput("b_wait",  waited,     4);
    checkOutput("b_start", start_sr_b, 4'b1000);
    checkOutput("b_old",   old_b,      4'b0001);
    repeat (4) tick();
    checkOutput("b_last_refresh", cur_b, 4'b1000);
    tick();
    checkOutput("b_abort_busy", busy_b, 1'b1);
    checkOutput("b_abort_cur",  cur_b,  4'b0);
    tick();
    checkOutput("b_err",     err_b,   1'b1);
    checkOutput("b_map",     map_b,   6'b10_01_00);
    checkOutput("b_spare",   spare_b, 2'd3);
    checkOutput("b_cnt",     cnt_b,   16'd0);
    checkOutput("b_idle",    busy_b,  1'b0);
    checkOutput("b_overrun", ovr_b,   1'b1);
    tick();
    checkOutput("b_retry_start", start_sr_b, 4'b1000);
    checkOutput("b_retry_old",   old_b,      4'b0001);
    enable_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
